// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the branch-predicting fetch stage.
//   NOP_INSTR  : instruction placed in IF/ID for a bubble (addi x0,x0,0)
//   ctr_t      : 2-bit saturating branch counter encodings
//   ctr_next() : saturating increment/decrement of a counter
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;  // value of every counter out of reset
    localparam ctr_t CTR_ALLOC = WT;   // value of a freshly allocated entry

    // Move the counter one step toward the observed outcome, pinned at 00/11.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_bht.sv
// ----------------------------------------------------------------------------
// btb_bht
// Direct-mapped branch target buffer with a 2-bit counter per entry.
//   clk, rst          : clock, asynchronous active-high reset
//   lookup_word_i     : fetch PC without its two zero LSBs
//   lookup_taken_o    : entry hits and its counter says taken
//   lookup_target_o   : stored target of the looked-up entry
//   upd_en_i          : a resolved branch is reported this cycle
//   upd_word_i        : resolved branch PC without its two zero LSBs
//   upd_taken_i       : actual outcome
//   upd_target_i      : actual taken target (LSBs already cleared)
// Lookup is purely combinational, so a same-cycle update to the same entry
// is only visible from the next cycle on.
// ----------------------------------------------------------------------------
module btb_bht
    import fetch_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-3:0] lookup_word_i,
    output logic            lookup_taken_o,
    output logic [XLEN-1:0] lookup_target_o,
    input  logic            upd_en_i,
    input  logic [XLEN-3:0] upd_word_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic              valid_q  [BTB_ENTRIES];
    ctr_t              ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]   target_q [BTB_ENTRIES];

    logic [IDX-1:0]    lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit;

    assign lk_idx = lookup_word_i[IDX-1:0];
    assign lk_tag = lookup_word_i[XLEN-3:IDX];
    assign up_idx = upd_word_i[IDX-1:0];
    assign up_tag = upd_word_i[XLEN-3:IDX];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign lookup_taken_o  = lk_hit && ctr_q[lk_idx][1];
    assign lookup_target_o = target_q[lk_idx];

    // NOTE: only valid bits and counters carry a reset; tag/target live in a
    // separate reset-less block so they can map onto plain RAM/flop arrays,
    // and a cleared valid bit already makes their contents irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                // NOTE: state is always written with <= so every flop samples
                // values from before the edge, independent of statement order.
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (upd_en_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
            end else if (upd_taken_i) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= CTR_ALLOC;
            end
        end
    end

    // A taken outcome always writes tag and target: on a hit the tag is
    // unchanged, on a miss this is the allocation.
    always_ff @(posedge clk) begin
        if (upd_en_i && upd_taken_i) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/if_stage_bpred.sv
// ----------------------------------------------------------------------------
// if_stage_bpred
// Instruction-fetch stage with BTB + 2-bit counter branch prediction.
//   clk, rst           : clock, asynchronous active-high reset
//   imem_addr          : fetch address (current PC, combinational)
//   imem_rdata         : instruction at imem_addr (combinational)
//   stall              : decode stall, holds PC and IF/ID
//   ex_redirect(_pc)   : flush and restart fetch at ex_redirect_pc
//   ex_update*         : resolved branch outcome for predictor training
//   if_pc/if_instr/if_valid/if_pred_taken/if_pred_target : IF/ID register
// Priority each cycle: redirect > stall > normal fetch. Predictor training
// runs regardless of stall/redirect.
// ----------------------------------------------------------------------------
module if_stage_bpred
    import fetch_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            ex_update,
    input  logic [XLEN-1:0] ex_update_pc,
    input  logic            ex_update_taken,
    input  logic [XLEN-1:0] ex_update_target,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_valid,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d;
    logic            if_taken_q, if_taken_d;
    logic [XLEN-1:0] if_target_q, if_target_d;

    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] update_target;

    // Instructions are word aligned: externally supplied addresses lose
    // their two LSBs, which are otherwise ignored.
    assign redirect_pc   = {ex_redirect_pc[XLEN-1:2], 2'b00};
    assign update_target = {ex_update_target[XLEN-1:2], 2'b00};

    logic unused_low_bits;
    assign unused_low_bits = ^{ex_redirect_pc[1:0], ex_update_pc[1:0],
                               ex_update_target[1:0]};

    btb_bht #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk             (clk),
        .rst             (rst),
        .lookup_word_i   (pc_q[XLEN-1:2]),
        .lookup_taken_o  (pred_taken),
        .lookup_target_o (pred_target),
        .upd_en_i        (ex_update),
        .upd_word_i      (ex_update_pc[XLEN-1:2]),
        .upd_taken_i     (ex_update_taken),
        .upd_target_i    (update_target)
    );

    // Sequential +4 wraps naturally at 2^XLEN.
    assign next_pc   = pred_taken ? pred_target : pc_q + XLEN'(4);
    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // branches below leaves a variable unassigned (no latch).
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        if_taken_d  = if_taken_q;
        if_target_d = if_target_q;
        if (ex_redirect) begin
            pc_d       = redirect_pc;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
            if_taken_d = 1'b0;
        end else if (!stall) begin
            pc_d        = next_pc;
            if_pc_d     = pc_q;
            if_instr_d  = imem_rdata;
            if_valid_d  = 1'b1;
            if_taken_d  = pred_taken;
            if_target_d = next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC[XLEN-1:0];
            if_pc_q     <= '0;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
            if_taken_q  <= 1'b0;
            if_target_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            if_taken_q  <= if_taken_d;
            if_target_q <= if_target_d;
        end
    end

    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_valid       = if_valid_q;
    assign if_pred_taken  = if_taken_q;
    assign if_pred_target = if_target_q;

endmodule

// File: doc/if_stage_bpred.md
Name: if_stage_bpred

Overview:
- Parametrised instruction-fetch stage; successor to the fixed 64-bit fetch stage.
- Owns the PC and drives the instruction-memory address.
- Predicts branches with a direct-mapped branch target buffer (BTB) plus 2-bit saturating counters.
- Registers the fetched instruction into the IF/ID pipeline register; honours stall from decode and redirect/update from execute.

Parameters:
- XLEN, 64, PC/address width in bits.
- BTB_ENTRIES, 16, number of BTB/counter entries (power of 2, >= 2); IDX = log2(BTB_ENTRIES).
- RESET_PC, 64'h0, PC value loaded on reset (truncated to XLEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  XLEN  fetch address; equals current pc, combinational.
- imem_rdata  in  32  instruction returned combinationally for imem_addr.
- stall  in  1  decode stall; hold pc and IF/ID register.
- ex_redirect  in  1  execute-stage mispredict/flush request.
- ex_redirect_pc  in  XLEN  correct next PC on redirect.
- ex_update  in  1  a resolved branch is reported this cycle.
- ex_update_pc  in  XLEN  PC of the resolved branch.
- ex_update_taken  in  1  actual branch outcome.
- ex_update_target  in  XLEN  actual taken target.
- if_pc  out  XLEN  IF/ID: PC of the fetched instruction.
- if_instr  out  32  IF/ID: fetched instruction.
- if_valid  out  1  IF/ID: instruction valid.
- if_pred_taken  out  1  IF/ID: prediction used for this instruction.
- if_pred_target  out  XLEN  IF/ID: predicted next PC (pc+4 when not taken).

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; if_pc=0; if_instr=32'h00000013 (NOP); if_valid=0; if_pred_taken=0; if_pred_target=0.
  - All BTB valid bits=0; all counters=2'b01 (weakly not-taken).
  - Reset asserted mid-stream discards all state immediately.
- Indexing:
  - idx = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
  - pc[1:0] is always 0; ex_redirect_pc[1:0] and ex_update_target[1:0] are forced to 0.
- Prediction (combinational on current pc):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && counter[idx][1].
  - next_pc = pred_taken ? btb_target[idx] : pc+4. Addition wraps modulo 2^XLEN.
- Per-cycle priority, highest first:
  - ex_redirect: pc <= ex_redirect_pc; IF/ID <= bubble (if_valid=0, if_instr=NOP, if_pred_taken=0). Overrides stall.
  - stall: pc and all IF/ID outputs hold.
  - normal: IF/ID <= {pc, imem_rdata, valid=1, pred_taken, next_pc}; pc <= next_pc.
- Latency: instruction at pc appears on IF/ID outputs 1 cycle later. Redirect target is fetched on the cycle after the redirect and is valid on IF/ID 2 cycles after it.
- Predictor update, independent of stall/redirect, written at the clock edge (idx/tag taken from ex_update_pc):
  - Hit: counter saturating +1 if taken, -1 if not (range 00..11). If taken, target is overwritten with ex_update_target.
  - Miss and taken: allocate; valid=1, tag, target written, counter=2'b10.
  - Miss and not taken: no change.
- A same-cycle lookup and update on the same index: the lookup sees pre-update state (no bypass).
- Counter is never below 00 or above 11.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - 2-bit counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - Reset counter value WNT; allocate value WT.
- Sub-module btb_bht, parametrised by XLEN and BTB_ENTRIES:
  - Holds valid/tag/target/counter arrays.
  - One combinational lookup port and one synchronous update port.
  - Shares the fetch stage's asynchronous reset.
- if_stage_bpred holds the PC, next-PC mux and IF/ID register.

Test Plan:
- Reset release, stall=0, imem returns 0x11111111: cycle 1 gives if_pc=0, if_valid=1, if_pred_taken=0; pc sequence 0,4,8,12; PC reads 0 throughout reset.
- Update pc=0x8, taken, target=0x40; later refetch 0x8: next if_pc after 0x8 is 0x40, if_pred_taken=1, if_pred_target=0x40.
- Two not-taken updates at 0x8 (counter 10->01->00), then a fetch of 0x8: pred_taken=0, next pc 0xC. A third not-taken update leaves the counter at 00.
- stall=1 for 3 cycles at pc=0x10: imem_addr and IF/ID outputs hold. ex_redirect=1 with pc=0x100 during the stall: next cycle if_valid=0 and if_instr=NOP; the following cycle if_pc=0x100.
- Aliasing with BTB_ENTRIES=16: train 0x8 taken; fetching 0x48 (same idx, different tag) gives a miss and pred_taken=0.
- Wrap-around: XLEN=32, redirect to 0xFFFFFFFC: the next fetch is pc=0x0.
